output_deskew_array: RTL and testbench
======================================

Name: output_deskew_array

Overview:
Receive-side counterpart of the systolic input skew buffer. Results leave the PE array columns staggered: column j is valid one cycle after column j-1. This block re-aligns the staggered results into full-width rows, one row per cycle, and hands them to the output/writeback buffer. It also counts rows per tile and flags any misaligned lane.

Parameters:
LANES, 32, number of array columns / lanes
DW, 16, data width per lane
ROWS, 32, aligned rows per tile before tile_done pulses

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
en  input  1  advance enable; 0 = stall, all state holds
data_in  input  LANES x DW  unpacked array, staggered column results
in_vld  input  LANES  per-lane valid accompanying data_in
data_out  output  LANES x DW  unpacked array, re-aligned row
out_vld  output  LANES  per-lane valid after de-skew
row_vld  output  1  combinational AND of out_vld: complete aligned row present
row_cnt  output  $clog2(ROWS)  rows accepted in current tile
tile_done  output  1  registered one-cycle pulse after the last row of a tile
skew_err  output  1  sticky misalignment flag

Behaviour:
- Clock, reset and enable:
  - One clock domain.
  - Reset is synchronous and active-high. On a clk edge with rst=1, all delay registers, data_out, out_vld, row_cnt, tile_done and skew_err go to 0. row_vld is therefore 0.
  - rst has priority over en.
- Lane delay:
  - Lane j is a shift register of depth LANES-j, carrying {vld, data}. Lane 0 has 32 stages; lane LANES-1 has 1 stage.
  - All lanes shift only when en=1. When en=0, every register holds and the outputs stay unchanged.
- Alignment and latency:
  - A beat entering lane j at enabled cycle t0+j appears on data_out[j] exactly LANES enabled cycles after t0.
  - Latency from lane 0 input to row output is LANES enabled cycles.
  - Throughput is one row per cycle; back-to-back tiles are allowed with no bubble.
- Data qualification: data_out[j] is meaningful only when out_vld[j]=1. Data is shifted regardless of vld, with no gating and no arithmetic.
- Row counter:
  - On an edge with en=1 and row_vld=1, row_cnt increments.
  - If row_cnt==ROWS-1 at that edge, row_cnt wraps to 0 and tile_done=1 for the next cycle only.
  - tile_done=0 on all other edges, including stalled edges.
- Skew error:
  - Set on an edge with en=1 when out_vld is neither all-0 nor all-1.
  - Sticky until rst.
  - Rows are still counted only when all lanes are valid.
- Boundary cases:
  - Stall mid-row: staggered input must also stall. Alignment is preserved because all lanes freeze together.
  - en=0 while row_vld=1: the row is not counted again. Downstream must sample on en.
  - Reset mid-tile: in-flight beats are discarded and row_cnt returns to 0. tile_done is not emitted for a partial tile.
  - in_vld asserted on a lane out of its stagger slot: propagates misaligned and produces skew_err when it reaches the output.

Decomposition:
- Shared package (cnn_pkg):
  - LANES and DW constants.
  - typedef lane_data_t = logic [DW-1:0].
  - typedef lane_bus_t = lane_data_t [LANES].
- One sub-module, deskew_lane:
  - Parameters DEPTH and DW.
  - Ports: clk, rst, en, din, vin, dout, vout.
  - Instantiated in a generate loop with DEPTH=LANES-j.
- The top holds the row counter, tile_done, skew_err and the row_vld AND.

Test Plan:
- Reset: rst=1 for 2 cycles with random data_in and in_vld=all-1 -> data_out all 0, out_vld=0, row_cnt=0, tile_done=0, skew_err=0.
- Single row: en=1; drive lane j with data 100+j and in_vld[j]=1 at cycle j (0..31), 0 otherwise -> at cycle 32, row_vld=1 for exactly 1 cycle, data_out[j]=100+j, row_cnt goes to 1.
- Stall: same as single row, plus en=0 for 5 cycles starting at cycle 10 (input stream paused too) -> row appears at cycle 37 with identical values; outputs hold during the stall; skew_err=0.
- Full tile: 32 consecutive staggered rows, row r lane j = r*32+j -> rows r=0..31 on cycles 32..63 in order; row_cnt 31 then wraps to 0; tile_done=1 on cycle 64 only; then 2nd tile back-to-back -> tile_done again at cycle 96.
- Skew error: drive lane 5 valid one cycle early (at cycle 4) -> skew_err=1 at first output mismatch and stays 1 until rst; row_cnt does not increment for the misaligned row.
- Reset mid-tile: rst at row 10 -> row_cnt=0, out_vld=0 next cycle; fresh 32-row tile -> tile_done after exactly 32 rows.

Source files
------------

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared lane geometry and bus types for the array output path.
package cnn_pkg;
    localparam int LANES = 32;
    localparam int DW = 16;
    typedef logic [DW-1:0] lane_data_t;
    typedef lane_data_t lane_bus_t [LANES];
endpackage

// File: rtl/deskew_lane.sv
// deskew_lane: enable-gated shift register of DEPTH stages carrying {vld, data}.
module deskew_lane #(
    parameter int DEPTH = 1,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] din,
    input  logic          vin,
    output logic [DW-1:0] dout,
    output logic          vout
);
    logic [DW-1:0]    d_q [DEPTH];
    logic [DEPTH-1:0] v_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                d_q[i] <= '0;
                v_q[i] <= 1'b0;
            end
        end else if (en) begin
            d_q[0] <= din;
            v_q[0] <= vin;
            for (int i = 1; i < DEPTH; i++) begin
                d_q[i] <= d_q[i-1];
                v_q[i] <= v_q[i-1];
            end
        end
    end
    assign dout = d_q[DEPTH-1];
    assign vout = v_q[DEPTH-1];
endmodule

// File: rtl/output_deskew_array.sv
// output_deskew_array: re-aligns staggered PE column results into rows, counts rows per tile
// and flags lanes that arrive out of their stagger slot.
module output_deskew_array
    import cnn_pkg::*;
#(
    parameter int LANES = cnn_pkg::LANES,
    parameter int DW = cnn_pkg::DW,
    parameter int ROWS = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [DW-1:0]           data_in [LANES],
    input  logic [LANES-1:0]        in_vld,
    output logic [DW-1:0]           data_out [LANES],
    output logic [LANES-1:0]        out_vld,
    output logic                    row_vld,
    output logic [$clog2(ROWS)-1:0] row_cnt,
    output logic                    tile_done,
    output logic                    skew_err
);
    localparam int CW = $clog2(ROWS);
    // Lane j enters j cycles late, so it needs LANES-j stages to line up with lane 0.
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        deskew_lane #(.DEPTH(LANES - j), .DW(DW)) u_lane (
            .clk (clk),
            .rst (rst),
            .en  (en),
            .din (data_in[j]),
            .vin (in_vld[j]),
            .dout(data_out[j]),
            .vout(out_vld[j])
        );
    end
    logic last;
    assign row_vld = &out_vld;
    assign last = row_cnt == CW'(ROWS - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            row_cnt   <= '0;
            tile_done <= 1'b0;
            skew_err  <= 1'b0;
        end else begin
            tile_done <= en && row_vld && last;
            if (en && row_vld)
                row_cnt <= last ? '0 : row_cnt + 1'b1;
            if (en && |out_vld && !row_vld)
                skew_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_output_deskew_array.sv
// tb_output_deskew_array: directed staggered streams checked every cycle against a
// history-indexed model, plus hand-computed pins at key cycles.
module tb_output_deskew_array;
    localparam int LANES = 32;
    localparam int DW = 16;
    localparam int ROWS = 32;

    logic             clk = 0;
    logic             rst = 1;
    logic             en = 1;
    logic [DW-1:0]    data_in [LANES];
    logic [LANES-1:0] in_vld = '0;
    logic [DW-1:0]    data_out [LANES];
    logic [LANES-1:0] out_vld;
    logic             row_vld;
    logic [4:0]       row_cnt;
    logic             tile_done;
    logic             skew_err;

    output_deskew_array #(.LANES(LANES), .DW(DW), .ROWS(ROWS)) dut (
        .clk(clk), .rst(rst), .en(en), .data_in(data_in), .in_vld(in_vld),
        .data_out(data_out), .out_vld(out_vld), .row_vld(row_vld),
        .row_cnt(row_cnt), .tile_done(tile_done), .skew_err(skew_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: every enabled input beat is logged by its enabled-cycle index k since reset;
    // the output on lane j is simply the beat logged LANES-j enabled cycles ago.
    bit            hv [LANES][64];
    logic [DW-1:0] hd [LANES][64];
    int            k = 0;
    logic [4:0]    cnt = 0;
    bit            td = 0, se = 0, live = 0;

    function automatic logic [LANES-1:0] mv();
        for (int j = 0; j < LANES; j++) begin
            int i = k - (LANES - j);
            mv[j] = (i >= 0) && hv[j][i % 64];
        end
    endfunction

    function automatic logic [DW-1:0] md(int j);
        int i = k - (LANES - j);
        md = (i >= 0) ? hd[j][i % 64] : '0;
    endfunction

    always @(posedge clk) begin
        logic [LANES-1:0] ev;
        if (rst) begin
            k = 0; cnt = 0; td = 0; se = 0; live = 1;
        end else if (en) begin
            ev = mv();
            td = (&ev) && (cnt == 5'(ROWS - 1));
            if (&ev) cnt = 5'((int'(cnt) + 1) % ROWS);
            if (ev != 0 && !(&ev)) se = 1;
            for (int j = 0; j < LANES; j++) begin
                hv[j][k % 64] = in_vld[j];
                hd[j][k % 64] = data_in[j];
            end
            k++;
        end else td = 0;
    end

    always @(negedge clk) begin
        logic [LANES-1:0] ev;
        bit ok;
        int bj;
        if (live) begin
            ev = mv();
            chk("ctrl", {out_vld, row_vld, row_cnt, tile_done, skew_err}, {ev, &ev, cnt, td, se});
            ok = 1; bj = 0;
            for (int j = LANES - 1; j >= 0; j--)
                if (ev[j] && data_out[j] !== md(j)) begin ok = 0; bj = j; end
            n_chk++;
            if (ok) n_pass++;
            else $display("FAIL data lane %0d: got %0h expected %0h at %0t", bj, data_out[bj], md(bj), $time);
        end
    end

    // Staggered stream generator: lane j carries row (s_c - j); s_early shifts one lane a slot early.
    int s_rows = 0, s_base = 0, s_early = -1, s_c = 0;
    bit s_allv = 0;

    task automatic start(int rows, int base, int early);
        s_rows = rows; s_base = base; s_early = early; s_c = 0;
    endtask

    task automatic drive();
        int r;
        bit v;
        for (int j = 0; j < LANES; j++) begin
            r = s_c - j + ((j == s_early) ? 1 : 0);
            v = s_allv || (r >= 0 && r < s_rows);
            in_vld[j] = v;
            data_in[j] = (v && !s_allv) ? DW'(s_base + r * LANES + j) : DW'($urandom);
        end
    endtask

    task automatic steps(int n, bit e);
        for (int t = 0; t < n; t++) begin
            en = e;
            if (e) begin drive(); s_c++; end
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset(int n);
        rst = 1; steps(n, 1); rst = 0;
    endtask

    initial begin
        for (int j = 0; j < LANES; j++) data_in[j] = '0;
        s_allv = 1;
        do_reset(2);
        s_allv = 0;
        chk("rst_out_vld", out_vld, 0);
        chk("rst_data", {data_out[0], data_out[31]}, 0);
        chk("rst_flags", {row_cnt, tile_done, skew_err}, 0);

        start(1, 100, -1);
        steps(32, 1);
        chk("row_vld_c32", row_vld, 1);
        chk("row_data", {data_out[0], data_out[7], data_out[31]}, {16'd100, 16'd107, 16'd131});
        steps(1, 1);
        chk("row_once", {row_vld, row_cnt}, {1'b0, 5'd1});

        start(1, 100, -1);
        steps(10, 1);
        steps(5, 0);
        steps(22, 1);
        chk("stall_row", {row_vld, data_out[5], skew_err}, {1'b1, 16'd105, 1'b0});
        steps(1, 1);
        chk("stall_cnt", row_cnt, 2);

        do_reset(1);
        start(64, 0, -1);
        steps(64, 1);
        chk("tile1_done", {tile_done, row_cnt, data_out[3]}, {1'b1, 5'd0, 16'd1027});
        steps(1, 1);
        chk("tile1_pulse", tile_done, 0);
        steps(31, 1);
        chk("tile2_done", {tile_done, row_cnt}, {1'b1, 5'd0});
        steps(2, 1);

        do_reset(1);
        start(1, 100, 5);
        steps(31, 1);
        chk("early_lane", {out_vld, skew_err}, {32'h0000_0020, 1'b0});
        steps(1, 1);
        chk("skew_set", {out_vld, row_vld, skew_err}, {32'hFFFF_FFDF, 1'b0, 1'b1});
        steps(5, 1);
        chk("skew_sticky", {skew_err, row_cnt}, {1'b1, 5'd0});

        do_reset(1);
        chk("skew_clr", skew_err, 0);
        start(64, 0, -1);
        steps(42, 1);
        chk("mid_cnt", row_cnt, 10);
        do_reset(1);
        chk("mid_rst", {row_cnt, out_vld, tile_done}, 0);
        start(32, 500, -1);
        steps(63, 1);
        chk("fresh_not_yet", tile_done, 0);
        steps(1, 1);
        chk("fresh_done", {tile_done, row_cnt}, {1'b1, 5'd0});
        steps(2, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
